// File: rtl/io_pkg.sv
// Shared constants and types for the IO input port: register addresses and status bit layout.
package io_pkg;

   localparam logic [3:0] IO_ADDR_SPEED = 4'h4;
   localparam logic [3:0] IO_ADDR_DIR   = 4'h8;
   localparam logic [3:0] IO_ADDR_STAT  = 4'hC;

   localparam int STAT_DIR = 0;
   localparam int STAT_SPD = 1;
   localparam int STAT_OVF = 2;

   // Field order matches the STAT_* indices so the struct drops straight into the status word.
   typedef struct packed {
      logic ovf;
      logic spd;
      logic dir;
   } io_stat_t;

   function automatic logic [31:0] stat_word(input io_stat_t s);
      return {29'b0, s};
   endfunction

endpackage

// File: rtl/io_debounce.sv
// One switch bit: two-flop synchroniser followed by a saturating stability counter.
// accept pulses (combinationally) in the cycle whose posedge moves level to the new value.
module io_debounce
   import io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 10000,
   parameter int CNT_W           = 14
) (
   input  logic CLK,
   input  logic RESET,
   input  logic raw,
   output logic level,
   output logic accept
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1_reg;
   logic             s2_reg;
   logic             level_reg;
   logic [CNT_W-1:0] cnt_reg;

   assign accept = (s2_reg != level_reg) && (cnt_reg == CNT_MAX);
   assign level  = level_reg;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         s1_reg    <= 1'b0;
         s2_reg    <= 1'b0;
         level_reg <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         s1_reg <= raw;
         s2_reg <= s1_reg;
         // Any return to the accepted level throws away accumulated progress.
         if (s2_reg == level_reg) begin
            cnt_reg <= '0;
         end else if (accept) begin
            level_reg <= s2_reg;
            cnt_reg   <= '0;
         end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/io_input_port.sv
// Memory-mapped switch input port: debounced SPEED/DIRECTION levels plus sticky change flags
// cleared by a status read. Define IO_IRQ_EN to add a registered IRQ output.
module io_input_port
   import io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 10000,
   parameter int CNT_W           = 14
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [1:0]  SPEED,
   input  logic        DIRECTION,
   input  logic [3:0]  IOAddr,
   input  logic        IOReadEn,
   output logic [31:0] IOReadData
`ifdef IO_IRQ_EN
   ,
   output logic        IRQ
`endif
);

   // Bits 1:0 carry SPEED, bit 2 carries DIRECTION.
   logic [2:0] raw_bits;
   logic [2:0] level_bits;
   logic [2:0] accept_bits;

   assign raw_bits = {DIRECTION, SPEED};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_deb
         io_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
         ) u_deb (
            .CLK   (CLK),
            .RESET (RESET),
            .raw   (raw_bits[gi]),
            .level (level_bits[gi]),
            .accept(accept_bits[gi])
         );
      end
   endgenerate

   logic     dir_ev;
   logic     spd_ev;
   logic     stat_clr;
   io_stat_t stat_reg;
   io_stat_t stat_next;

   assign dir_ev   = accept_bits[2];
   assign spd_ev   = accept_bits[0] | accept_bits[1];
   assign stat_clr = IOReadEn && (IOAddr == IO_ADDR_STAT);

   // A new event beats the clear; overflow only counts events landing on an uncleared flag.
   always_comb begin
      stat_next = stat_reg;
      if (stat_clr) begin
         stat_next = '0;
      end
      if (dir_ev) begin
         stat_next.dir = 1'b1;
      end
      if (spd_ev) begin
         stat_next.spd = 1'b1;
      end
      if (!stat_clr && ((dir_ev && stat_reg.dir) || (spd_ev && stat_reg.spd))) begin
         stat_next.ovf = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         stat_reg <= '0;
      end else begin
         stat_reg <= stat_next;
      end
   end

   always_comb begin
      IOReadData = 32'b0;
      case (IOAddr)
         IO_ADDR_SPEED: IOReadData = {28'b0, level_bits[1:0], 2'b00};
         IO_ADDR_DIR:   IOReadData = {31'b0, level_bits[2]};
         IO_ADDR_STAT:  IOReadData = stat_word(stat_reg);
         default:       IOReadData = 32'b0;
      endcase
   end

`ifdef IO_IRQ_EN
   logic irq_reg;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         irq_reg <= 1'b0;
      end else begin
         irq_reg <= stat_reg.dir | stat_reg.spd;
      end
   end

   assign IRQ = irq_reg;
`endif

endmodule

// File: doc/io_input_port.md
Name: io_input_port

Overview:
- Memory-mapped input peripheral on the MIPS IO bus: the read-side counterpart of the display write register.
- Synchronises and debounces the board switches (SPEED[1:0], DIRECTION) and serves them to the processor through IOReadData.
- Latches sticky change-event flags so software can poll for switch activity; a status read clears them.
- Replaces the bare combinational IOReadData mux in the top level.

Parameters:
DEBOUNCE_CYCLES, 10000, consecutive stable CLK cycles required to accept a new switch level (1 ms at 10 MHz); minimum 2
CNT_W, 14, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
CLK  in  1  10 MHz system clock (clock-divider output)
RESET  in  1  synchronous, active-high reset
SPEED  in  2  raw asynchronous speed switches
DIRECTION  in  1  raw asynchronous direction switch
IOAddr  in  4  processor IO address
IOReadEn  in  1  high for the one cycle in which the processor performs an IO load
IOReadData  out  32  read data, combinational from IOAddr and internal registers
IRQ  out  1  only when IO_IRQ_EN is defined (see Optional Feature)

Behaviour:
- Clocking and reset: one clock (CLK); reset is synchronous and active-high (RESET). All state is posedge CLK.
- Reset values: sync flops, stable levels, counters, event flags and overflow all 0. IOReadData therefore reads 0 at every address after reset.
- Synchroniser: each raw bit passes through 2 flops (s1 -> s2).
- Debounce, per bit, independent:
  - if s2 == stable: cnt <= 0.
  - otherwise cnt <= cnt + 1.
  - when cnt == DEBOUNCE_CYCLES-1 and s2 != stable: stable <= s2 and cnt <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES resets progress; the counter never wraps.
- Latency: a clean level change appears on stable 2 + DEBOUNCE_CYCLES cycles after the raw edge.
- Events:
  - dir_chg sets on the cycle DIRECTION's stable level changes (either edge).
  - spd_chg sets when either stable SPEED bit changes.
  - ovf sets if an event fires while its flag is already 1.
- Register map (IOAddr):
  - 0x4 -> {28'b0, speed_stable, 2'b00}
  - 0x8 -> {31'b0, dir_stable}
  - 0xC -> {29'b0, ovf, spd_chg, dir_chg}
  - any other address -> 32'b0
- Read-clear: on a posedge with IOReadEn=1 and IOAddr=0xC, all three flags are cleared. The value returned in that cycle is the pre-clear value.
- Simultaneous event and clear in the same cycle: the set wins, so the flag is 1 afterwards. ovf is not set by that event because it is the clear cycle.
- Reads at 0x4 and 0x8 have no side effects. IOReadEn at any other address is ignored.
- Reset mid-debounce: the counter is discarded and the stable level returns to 0. No event is raised by the reset itself.

Optional Feature:
- IO_IRQ_EN defined:
  - IRQ output exists.
  - IRQ is a registered OR of dir_chg and spd_chg: it rises 1 cycle after a flag sets and falls 1 cycle after the read-clear.
  - Reset value 0.
- IO_IRQ_EN undefined: the IRQ port and its flop are absent. All other behaviour is identical.

Decomposition:
- Shared package io_pkg holds:
  - address constants IO_ADDR_SPEED=4'h4, IO_ADDR_DIR=4'h8, IO_ADDR_STAT=4'hC
  - status bit indices STAT_DIR=0, STAT_SPD=1, STAT_OVF=2
- Sub-module io_debounce: 1-bit synchroniser plus debounce counter, parameterised by DEBOUNCE_CYCLES and CNT_W. Instantiated 3 times.
- Event logic and the read mux stay in io_input_port.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3):
- Reset, then read 0x4, 0x8, 0xC, 0x0 -> all 32'h0; IRQ=0.
- SPEED=2'b11 held steady -> 0x4 reads 32'h0 through cycle 5 and 32'h0000000C from cycle 6; 0xC reads 32'h2.
- DIRECTION pulses high for 3 cycles then returns low -> 0x8 stays 0 and 0xC stays 0 (glitch rejected).
- DIRECTION goes 0->1 and is held, then the first read of 0xC with IOReadEn -> returns 32'h1; the next read returns 32'h0. With IO_IRQ_EN, IRQ goes 1 then 0 one cycle after the clear.
- Two DIRECTION toggles with no read in between -> 0xC reads 32'h5 (ovf+dir_chg).
- Event lands on the same cycle as the read-clear of 0xC -> that read returns the old value and the next read shows the flag still set. Separately, RESET asserted mid-debounce -> all registers read 0 and no event flag is set.
